// File: rtl/cpu_types_pkg.sv
// Shared CPU types: 32-bit word type, data-cache FSM states and the hit-count dump address.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Address the data cache writes its hit count to after a flush, when counting is built in.
  localparam word_t HITCOUNT_ADDR = 32'h0000_3100;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    FETCH,
    FLUSH,
    FLUSH_WB,
    COUNT,
    DONE
  } dcache_state_t;

endpackage

// File: rtl/dcache_if.sv
// Data-cache bus bundle: datapath request/response and memory-side transfer signals.
// The slave modport is the cache's view; master is the datapath + memory view.
interface dcache_if;
  import cpu_types_pkg::*;

  // Datapath side
  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  halt;
  logic  dhit;
  word_t dmemload;
  logic  flushed;

  // Memory side
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  dwait;
  word_t dload;

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
    output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dwait, dload,
    input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
  );

endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-back, one-word-line data cache with halt-triggered flush.
// Optional feature: define DCACHE_HITCOUNT_EN to count hits and write the count to
// HITCOUNT_ADDR after the flush completes.
module dcache
  import cpu_types_pkg::*;
#(
  parameter int unsigned SETS = 16
) (
  input logic     CLK,
  input logic     nRST,
  dcache_if.slave dif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

`ifdef DCACHE_HITCOUNT_EN
  localparam dcache_state_t WRAP_STATE = COUNT;
`else
  localparam dcache_state_t WRAP_STATE = DONE;
`endif

  logic [SETS-1:0] valid_q, dirty_q;
  tag_t            tag_q  [SETS];
  word_t           data_q [SETS];

  dcache_state_t state_q, state_d;
  idx_t          flush_idx_q, flush_idx_d;

  idx_t req_idx;
  tag_t req_tag;
  logic req;
  logic line_hit;
  logic last_line;
  logic fill_en, store_en, clean_en;

  logic  dhit, flushed, dREN, dWEN;
  word_t dmemload, daddr, dstore;

  // Byte-offset bits never matter to a word cache.
  logic unused_offset;
  assign unused_offset = ^dif.dmemaddr[1:0];

  assign req_idx   = dif.dmemaddr[IDX_W+1:2];
  assign req_tag   = dif.dmemaddr[31:IDX_W+2];
  assign req       = dif.dmemREN | dif.dmemWEN;
  assign line_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign last_line = (flush_idx_q == idx_t'(SETS - 1));

`ifdef DCACHE_HITCOUNT_EN
  word_t hit_count_q;
  logic  after_fetch_q;

  // Count hits, skipping the one that completes a miss right after a fill.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count_q   <= '0;
      after_fetch_q <= 1'b0;
    end else begin
      after_fetch_q <= fill_en;
      if (dhit && !after_fetch_q) hit_count_q <= hit_count_q + 32'd1;
    end
  end
`endif

  // State and flush-index register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      flush_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
    end
  end

  // Line storage: fill on fetch, update on store hit, clean on flush write-back.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (fill_en) begin
        data_q[req_idx]  <= dif.dload;
        tag_q[req_idx]   <= req_tag;
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end else if (store_en) begin
        data_q[req_idx]  <= dif.dmemstore;
        dirty_q[req_idx] <= 1'b1;
      end
      if (clean_en) dirty_q[flush_idx_q] <= 1'b0;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    dhit        = 1'b0;
    dmemload    = '0;
    flushed     = 1'b0;
    dREN        = 1'b0;
    dWEN        = 1'b0;
    daddr       = '0;
    dstore      = '0;
    fill_en     = 1'b0;
    store_en    = 1'b0;
    clean_en    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dif.halt) begin
          state_d     = FLUSH;
          flush_idx_d = '0;
        end else if (req) begin
          if (line_hit) begin
            dhit     = 1'b1;
            dmemload = data_q[req_idx];
            store_en = dif.dmemWEN;
          end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d = WB;
          end else begin
            state_d = FETCH;
          end
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[req_idx], req_idx, 2'b00};
        dstore = data_q[req_idx];
        if (!dif.dwait) state_d = FETCH;
      end
      FETCH: begin
        dREN  = 1'b1;
        daddr = {dif.dmemaddr[31:2], 2'b00};
        if (!dif.dwait) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
          state_d = FLUSH_WB;
        end else if (last_line) begin
          state_d = WRAP_STATE;
        end else begin
          flush_idx_d = flush_idx_q + 1'b1;
        end
      end
      FLUSH_WB: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[flush_idx_q], flush_idx_q, 2'b00};
        dstore = data_q[flush_idx_q];
        if (!dif.dwait) begin
          clean_en = 1'b1;
          if (last_line) begin
            state_d = WRAP_STATE;
          end else begin
            flush_idx_d = flush_idx_q + 1'b1;
            state_d     = FLUSH;
          end
        end
      end
      COUNT: begin
`ifdef DCACHE_HITCOUNT_EN
        dWEN   = 1'b1;
        daddr  = HITCOUNT_ADDR;
        dstore = hit_count_q;
        if (!dif.dwait) state_d = DONE;
`else
        state_d = DONE;
`endif
      end
      DONE: begin
        flushed = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dif.dhit     = dhit;
  assign dif.dmemload = dmemload;
  assign dif.flushed  = flushed;
  assign dif.dREN     = dREN;
  assign dif.dWEN     = dWEN;
  assign dif.daddr    = daddr;
  assign dif.dstore   = dstore;

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: vector table of requests plus hand sequences for flush
// and reset-abort, with a latency-2 memory model checking transfers against a scoreboard.
module tb_dcache;
  import cpu_types_pkg::*;

  localparam int LAT = 2;

  typedef struct {
    logic  is_wr;
    word_t addr;
    word_t data;
  } xfer_t;

  typedef struct {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t wdata;
    logic  wb;
    word_t wb_addr;
    word_t wb_data;
    int    cycles;
    word_t load;
  } vec_t;

  logic CLK = 1'b0;
  logic nRST;

  always #5 CLK = ~CLK;

  dcache_if dif ();

  dcache #(.SETS(16)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .dif (dif)
  );

  xfer_t sb_q[$];
  word_t mem[word_t];
  int    n_vec = 0;
  int    n_err = 0;
  int    exp_hits = 0;

  int    mcnt;
  logic  busy_wr;
  word_t busy_addr;

  function automatic word_t mem_rd(word_t a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hBEEF_0000;
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Memory: completes each transfer after LAT busy cycles and checks it against the scoreboard.
  initial begin : mem_model
    xfer_t exp;
    mcnt      = 0;
    busy_wr   = 1'b0;
    busy_addr = '0;
    dif.dwait = 1'b1;
    dif.dload = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (!nRST || !(dif.dREN || dif.dWEN)) begin
        mcnt      = 0;
        dif.dwait = 1'b1;
        dif.dload = '0;
      end else begin
        if (dif.dREN && dif.dWEN) check("xfer_both_req", 32'd1, 32'd0);
        if (mcnt > 0) begin
          check("xfer_hold_kind", word_t'(dif.dWEN), word_t'(busy_wr));
          check("xfer_hold_addr", dif.daddr, busy_addr);
        end
        busy_wr   = dif.dWEN;
        busy_addr = dif.daddr;
        if (mcnt < LAT) begin
          mcnt++;
          dif.dwait = 1'b1;
        end else begin
          mcnt      = 0;
          dif.dwait = 1'b0;
          if (dif.dWEN) mem[dif.daddr] = dif.dstore;
          else dif.dload = mem_rd(dif.daddr);
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_xfer: got wr=%0b addr %h data %h, want no transfer",
                     dif.dWEN, dif.daddr, dif.dstore);
          end else begin
            exp = sb_q.pop_front();
            check("xfer_kind", word_t'(dif.dWEN), word_t'(exp.is_wr));
            check("xfer_addr", dif.daddr, exp.addr);
            if (exp.is_wr) check("xfer_data", dif.dstore, exp.data);
          end
        end
      end
    end
  end

  // Issue one request, wait (bounded) for dhit, check latency/data and drained transfers.
  task automatic run_vec(input vec_t v, input int idx);
    int   cyc;
    logic hit;
    @(posedge CLK);
    #1;
    dif.dmemREN   = v.ren;
    dif.dmemWEN   = v.wen;
    dif.dmemaddr  = v.addr;
    dif.dmemstore = v.wdata;
    dif.halt      = 1'b0;
    if (v.wb) sb_q.push_back('{1'b1, v.wb_addr, v.wb_data});
    if (v.cycles > 0) sb_q.push_back('{1'b0, {v.addr[31:2], 2'b00}, 32'h0});
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc <= 20) begin
      @(negedge CLK);
      if (dif.dhit) hit = 1'b1;
      else begin
        cyc++;
        @(posedge CLK);
        #1;
      end
    end
    if (!hit) begin
      n_vec++;
      n_err++;
      $display("FAIL vec%0d_no_hit: got no dhit in 20 cycles, want dhit after %0d", idx, v.cycles);
    end else begin
      check($sformatf("vec%0d_latency", idx), word_t'(cyc), word_t'(v.cycles));
      check($sformatf("vec%0d_idle_mem", idx), word_t'({dif.dREN, dif.dWEN}), 32'd0);
      if (v.ren && !v.wen) check($sformatf("vec%0d_dmemload", idx), dif.dmemload, v.load);
      if (cyc == 0) exp_hits++;
    end
    @(posedge CLK);
    #1;
    dif.dmemREN = 1'b0;
    dif.dmemWEN = 1'b0;
    check($sformatf("vec%0d_xfers_done", idx), word_t'(sb_q.size()), 32'd0);
  endtask

  vec_t vt[13];
  vec_t v_abort_st, v_abort_ld;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish by 500us, want finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic done;
    // ren wen addr wdata wb wb_addr wb_data cycles load
    vt[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0, 32'h0, 4, 32'hDEAD_BEEF};
    vt[1]  = '{1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 0, 32'h0};
    vt[2]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0, 32'h0, 0, 32'h1234_5678};
    vt[3]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 1'b1, 32'h0000_0040, 32'h1234_5678, 7,
               32'hBEEF_0080};
    vt[4]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0, 32'h0, 4, 32'h1234_5678};
    vt[5]  = '{1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, 4, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'h0, 32'h0, 0, 32'hCAFE_F00D};
    vt[7]  = '{1'b0, 1'b1, 32'h1000_0048, 32'h1111_2222, 1'b0, 32'h0, 32'h0, 4, 32'h0};
    vt[8]  = '{1'b1, 1'b0, 32'h0000_0048, 32'h0, 1'b1, 32'h1000_0048, 32'h1111_2222, 7,
               32'hBEEF_0048};
    vt[9]  = '{1'b0, 1'b1, 32'h0000_007C, 32'hA5A5_A5A5, 1'b0, 32'h0, 32'h0, 4, 32'h0};
    vt[10] = '{1'b1, 1'b0, 32'h0000_007F, 32'h0, 1'b0, 32'h0, 32'h0, 0, 32'hA5A5_A5A5};
    vt[11] = '{1'b0, 1'b1, 32'h0000_0044, 32'h0000_0055, 1'b0, 32'h0, 32'h0, 0, 32'h0};
    vt[12] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b0, 32'h0, 32'h0, 0, 32'h0000_0055};
    v_abort_st = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_9999, 1'b0, 32'h0, 32'h0, 4, 32'h0};
    v_abort_ld = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'h0, 32'h0, 4, 32'h1234_5678};

    mem[32'h0000_0040] = 32'hDEAD_BEEF;

    nRST          = 1'b0;
    dif.dmemREN   = 1'b0;
    dif.dmemWEN   = 1'b0;
    dif.dmemaddr  = '0;
    dif.dmemstore = '0;
    dif.halt      = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("rst_dhit", word_t'(dif.dhit), 32'd0);
    check("rst_flushed", word_t'(dif.flushed), 32'd0);
    check("rst_dREN", word_t'(dif.dREN), 32'd0);
    check("rst_dWEN", word_t'(dif.dWEN), 32'd0);
    check("rst_daddr", dif.daddr, 32'd0);
    check("rst_dstore", dif.dstore, 32'd0);
    check("rst_dmemload", dif.dmemload, 32'd0);

    for (int i = 0; i < 13; i++) run_vec(vt[i], i);

    // Flush: two dirty lines (index 1 and 15) written back in index order.
    sb_q.push_back('{1'b1, 32'h0000_0044, 32'h0000_0055});
    sb_q.push_back('{1'b1, 32'h0000_007C, 32'hA5A5_A5A5});
`ifdef DCACHE_HITCOUNT_EN
    sb_q.push_back('{1'b1, HITCOUNT_ADDR, word_t'(exp_hits)});
`endif
    @(posedge CLK);
    #1;
    dif.halt     = 1'b1;
    dif.dmemREN  = 1'b1;
    dif.dmemaddr = 32'h0000_0044;
    @(negedge CLK);
    check("halt_priority_dhit", word_t'(dif.dhit), 32'd0);
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge CLK);
      if (dif.flushed) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL flush_timeout: got flushed=0 after 300 cycles, want 1");
    end
    check("flush_xfers_done", word_t'(sb_q.size()), 32'd0);
    dif.halt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("done_flushed", word_t'(dif.flushed), 32'd1);
      check("done_dhit", word_t'(dif.dhit), 32'd0);
      check("done_mem_idle", word_t'({dif.dREN, dif.dWEN}), 32'd0);
    end
    dif.dmemREN = 1'b0;

    // Reset clears the flush and the cache contents.
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(negedge CLK);
    check("rst2_flushed", word_t'(dif.flushed), 32'd0);

    // Reset aborts a write-back in progress; the dirty line is then gone.
    run_vec(v_abort_st, 13);
    @(posedge CLK);
    #1;
    dif.dmemREN  = 1'b1;
    dif.dmemaddr = 32'h0000_0080;
    @(negedge CLK);
    check("abort_miss_dhit", word_t'(dif.dhit), 32'd0);
    @(posedge CLK);
    #3;
    check("abort_wb_dWEN", word_t'(dif.dWEN), 32'd1);
    check("abort_wb_dwait", word_t'(dif.dwait), 32'd1);
    nRST = 1'b0;
    #1;
    check("abort_dWEN_drop", word_t'(dif.dWEN), 32'd0);
    check("abort_dREN_low", word_t'(dif.dREN), 32'd0);
    check("abort_daddr", dif.daddr, 32'd0);
    dif.dmemREN = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    run_vec(v_abort_ld, 14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
